// File: rtl/time_set_ctrl_pkg.sv
// Shared constants, enums and wrap helper for the clock time-setting controller.
package time_set_ctrl_pkg;

  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;

  typedef enum logic [1:0] {FLD_NONE, FLD_H, FLD_M, FLD_S} field_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_COMMIT} state_e;

  // One step up or down inside 0..max, wrapping at both ends.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max,
                                           input logic up);
    if (up) return (v >= max) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Switch/button inputs, running time in, shadow time and status out.
interface time_set_ctrl_if #(parameter int HW = 5);
  logic          sel_hours, sel_minutes, sel_seconds;
  logic          btn_inc, btn_dec;
  logic [HW-1:0] cur_hours;
  logic [5:0]    cur_minutes, cur_seconds;
  logic          editing, set_valid;
  logic [HW-1:0] set_hours;
  logic [5:0]    set_minutes, set_seconds;
  logic          led_hours, led_minutes, led_seconds;

  modport master (
    output sel_hours, sel_minutes, sel_seconds, btn_inc, btn_dec,
           cur_hours, cur_minutes, cur_seconds,
    input  editing, set_valid, set_hours, set_minutes, set_seconds,
           led_hours, led_minutes, led_seconds
  );

  modport slave (
    input  sel_hours, sel_minutes, sel_seconds, btn_inc, btn_dec,
           cur_hours, cur_minutes, cur_seconds,
    output editing, set_valid, set_hours, set_minutes, set_seconds,
           led_hours, led_minutes, led_seconds
  );
endinterface

// File: rtl/time_set_ctrl_btn_repeat.sv
// Button synchroniser + rising-edge detect + hold auto-repeat; emits a registered step pulse.
module btn_repeat #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_step
);
  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic          r_s1, r_s2, r_s3, r_rep, r_step;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_tgt;
  logic          w_rise, w_fire;

  // r_cnt counts held cycles since the last step; first target is the delay, then the period.
  assign w_rise = r_s2 & ~r_s3;
  assign w_tgt  = r_rep ? CW'(REPEAT_PER) : CW'(REPEAT_DLY);
  assign w_fire = r_s2 & (w_rise | (r_cnt == w_tgt));
  assign o_step = r_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_step <= 1'b0;
      r_rep  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_step <= w_fire;
      if (!r_s2) begin
        r_cnt <= '0;
        r_rep <= 1'b0;
      end else if (w_fire) begin
        r_cnt <= CW'(1);
        if (!w_rise) r_rep <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: select field, snapshot running time, step with repeat, commit strobe.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int HOUR_MAX   = 23,
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic            clk,
  input  logic            rst,
  time_set_ctrl_if.slave  bus
);
  localparam int HW = $clog2(HOUR_MAX + 1);

  logic [2:0]    r_sel_s1, r_sel_s2;
  state_e        r_state, w_next;
  field_e        w_fld;
  logic          w_any_sel, w_inc, w_dec;
  logic [HW-1:0] r_hours;
  logic [5:0]    r_minutes, r_seconds;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_s1 <= '0;
      r_sel_s2 <= '0;
    end else begin
      r_sel_s1 <= {bus.sel_hours, bus.sel_minutes, bus.sel_seconds};
      r_sel_s2 <= r_sel_s1;
    end
  end

  assign w_any_sel = |r_sel_s2;

  always_comb begin
    w_fld = FLD_NONE;
    if      (r_sel_s2[2]) w_fld = FLD_H;
    else if (r_sel_s2[1]) w_fld = FLD_M;
    else if (r_sel_s2[0]) w_fld = FLD_S;
  end

  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_inc (
    .clk(clk), .rst(rst), .i_btn(bus.btn_inc), .o_step(w_inc)
  );
  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dec (
    .clk(clk), .rst(rst), .i_btn(bus.btn_dec), .o_step(w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_sel)  w_next = ST_EDIT;
      ST_EDIT:   if (!w_any_sel) w_next = ST_COMMIT;
      ST_COMMIT: w_next = w_any_sel ? ST_EDIT : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Shadow loads only on entry from IDLE; a re-entry straight from COMMIT keeps the edited value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hours   <= '0;
      r_minutes <= '0;
      r_seconds <= '0;
    end else if (r_state == ST_IDLE && w_any_sel) begin
      r_hours   <= (bus.cur_hours   > HW'(HOUR_MAX)) ? '0 : bus.cur_hours;
      r_minutes <= (bus.cur_minutes > 6'(MIN_MAX))   ? '0 : bus.cur_minutes;
      r_seconds <= (bus.cur_seconds > 6'(SEC_MAX))   ? '0 : bus.cur_seconds;
    end else if (r_state == ST_EDIT && (w_inc ^ w_dec)) begin
      case (w_fld)
        FLD_H:   r_hours   <= HW'(wrap_step(6'(r_hours), 6'(HOUR_MAX), w_inc));
        FLD_M:   r_minutes <= wrap_step(r_minutes, 6'(MIN_MAX), w_inc);
        FLD_S:   r_seconds <= wrap_step(r_seconds, 6'(SEC_MAX), w_inc);
        default: ;
      endcase
    end
  end

  assign bus.editing     = (r_state != ST_IDLE);
  assign bus.set_valid   = (r_state == ST_COMMIT);
  assign bus.set_hours   = r_hours;
  assign bus.set_minutes = r_minutes;
  assign bus.set_seconds = r_seconds;
  assign bus.led_hours   = (r_state == ST_EDIT) && (w_fld == FLD_H);
  assign bus.led_minutes = (r_state == ST_EDIT) && (w_fld == FLD_M);
  assign bus.led_seconds = (r_state == ST_EDIT) && (w_fld == FLD_S);
endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised + directed bench for time_set_ctrl against a field-arithmetic reference model.
module tb_time_set_ctrl;
  localparam int DLY = 8;
  localparam int PER = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_set_ctrl_if #(.HW(5)) bus ();
  time_set_ctrl_if #(.HW(4)) bus2 ();

  time_set_ctrl #(.HOUR_MAX(23), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  time_set_ctrl #(.HOUR_MAX(11), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut12 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int n_chk = 0, n_err = 0;
  int n_strobe = 0, exp_strobe = 0;
  int m_h, m_m, m_s, m_fld;

  always @(negedge clk) if (bus.set_valid) n_strobe++;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int wrapv(input int v, input int d, input int n);
    return ((v + d) % n + n) % n;
  endfunction

  // Steps from a hold of h synced cycles: one at once, then at DLY, DLY+PER, ...
  function automatic int nsteps(input int h);
    int n = 1;
    if (h - 1 >= DLY) n += (h - 1 - DLY) / PER + 1;
    return n;
  endfunction

  task automatic chk_shadow(input string tag);
    chk({tag, "_h"}, int'(bus.set_hours),   m_h);
    chk({tag, "_m"}, int'(bus.set_minutes), m_m);
    chk({tag, "_s"}, int'(bus.set_seconds), m_s);
  endtask

  task automatic begin_edit(input logic sh, input logic sm, input logic ss,
                            input int ch, input int cm, input int cs);
    bus.cur_hours   = 5'(ch);
    bus.cur_minutes = 6'(cm);
    bus.cur_seconds = 6'(cs);
    bus.sel_hours = sh; bus.sel_minutes = sm; bus.sel_seconds = ss;
    m_h = (ch > 23) ? 0 : ch;
    m_m = (cm > 59) ? 0 : cm;
    m_s = (cs > 59) ? 0 : cs;
    m_fld = sh ? 1 : sm ? 2 : ss ? 3 : 0;
    tick(4);
    chk("editing", int'(bus.editing), 1);
    chk("led_h", int'(bus.led_hours),   int'(m_fld == 1));
    chk("led_m", int'(bus.led_minutes), int'(m_fld == 2));
    chk("led_s", int'(bus.led_seconds), int'(m_fld == 3));
    chk_shadow("load");
  endtask

  // op: 0 inc, 1 dec, 2 both together
  task automatic press(input int op, input int h);
    int d;
    bus.btn_inc = (op != 1);
    bus.btn_dec = (op != 0);
    tick(h);
    bus.btn_inc = 1'b0;
    bus.btn_dec = 1'b0;
    tick(7);
    if (op != 2) begin
      d = nsteps(h) * ((op == 0) ? 1 : -1);
      case (m_fld)
        1: m_h = wrapv(m_h, d, 24);
        2: m_m = wrapv(m_m, d, 60);
        3: m_s = wrapv(m_s, d, 60);
        default: ;
      endcase
    end
    chk_shadow("step");
  endtask

  task automatic end_edit();
    int seen = 0;
    bus.sel_hours = 1'b0; bus.sel_minutes = 1'b0; bus.sel_seconds = 1'b0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick(1);
      if (bus.set_valid) seen = 1;
    end
    chk("strobe_seen", seen, 1);
    if (seen == 1) begin
      exp_strobe++;
      chk("commit_ed", int'(bus.editing), 1);
      chk_shadow("commit");
      tick(1);
      chk("strobe_1cyc", int'(bus.set_valid), 0);
      chk("idle_ed", int'(bus.editing), 0);
    end
  endtask

  initial begin
    int s0, seen;
    logic [2:0] sel;
    int st2 [2] = '{11, 0};
    int ex2 [2] = '{0, 11};
    bus.sel_hours = 0; bus.sel_minutes = 0; bus.sel_seconds = 0;
    bus.btn_inc = 0; bus.btn_dec = 0;
    bus.cur_hours = 0; bus.cur_minutes = 0; bus.cur_seconds = 0;
    bus2.sel_hours = 0; bus2.sel_minutes = 0; bus2.sel_seconds = 0;
    bus2.btn_inc = 0; bus2.btn_dec = 0;
    bus2.cur_hours = 0; bus2.cur_minutes = 0; bus2.cur_seconds = 0;
    tick(3);
    chk("rst_ed", int'(bus.editing), 0);
    chk("rst_sv", int'(bus.set_valid), 0);
    chk("rst_led", int'({bus.led_hours, bus.led_minutes, bus.led_seconds}), 0);
    chk("rst_sh", int'(bus.set_hours) + int'(bus.set_minutes) + int'(bus.set_seconds), 0);
    rst = 1'b0;
    tick(2);

    begin_edit(0, 1, 0, 12, 34, 56); press(0, 1); end_edit();
    chk("t2_min", int'(bus.set_minutes), 35);
    begin_edit(0, 1, 0, 5, 59, 7);   press(0, 1); end_edit();
    begin_edit(1, 0, 0, 0, 10, 10);  press(1, 1); end_edit();
    chk("t3_h23", int'(bus.set_hours), 23);
    begin_edit(0, 0, 1, 3, 4, 10);   press(0, 20);
    chk("t4_hold20", int'(bus.set_seconds), 14);
    end_edit();
    begin_edit(0, 1, 0, 1, 2, 3);    press(2, 1); press(2, 15); end_edit();
    begin_edit(1, 0, 1, 30, 20, 40); press(0, 1); end_edit();
    chk("t6_h", int'(bus.set_hours), 1);

    for (int k = 0; k < 25; k++) begin
      sel = 3'($urandom_range(1, 7));
      begin_edit(sel[2], sel[1], sel[0], $urandom_range(0, 31),
                 $urandom_range(0, 63), $urandom_range(0, 63));
      for (int j = 0; j < int'($urandom_range(1, 3)); j++)
        press($urandom_range(0, 2), $urandom_range(1, 24));
      end_edit();
    end

    // reset in the middle of an edit
    begin_edit(0, 0, 1, 1, 1, 1); press(0, 1);
    rst = 1'b1;
    bus.sel_seconds = 1'b0;
    tick(1);
    chk("rmid_ed", int'(bus.editing), 0);
    chk("rmid_sv", int'(bus.set_valid), 0);
    chk("rmid_led", int'(bus.led_seconds), 0);
    chk("rmid_sh", int'(bus.set_seconds), 0);
    tick(1);
    rst = 1'b0;
    s0 = n_strobe;
    tick(10);
    chk("rmid_nostrobe", n_strobe, s0);

    // 12h build: 11 +1 -> 0, 0 -1 -> 11
    for (int c = 0; c < 2; c++) begin
      bus2.cur_hours = 4'(st2[c]);
      bus2.sel_hours = 1'b1;
      tick(4);
      chk("h12_led", int'(bus2.led_hours), 1);
      chk("h12_load", int'(bus2.set_hours), st2[c]);
      bus2.btn_inc = (c == 0);
      bus2.btn_dec = (c == 1);
      tick(1);
      bus2.btn_inc = 1'b0;
      bus2.btn_dec = 1'b0;
      tick(7);
      bus2.sel_hours = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        tick(1);
        if (bus2.set_valid) seen = 1;
      end
      chk("h12_strobe", seen, 1);
      chk("h12_wrap", int'(bus2.set_hours), ex2[c]);
      tick(3);
    end

    tick(3);
    chk("strobe_count", n_strobe, exp_strobe);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
